// File: rtl/mixer_dot.sv
// Mixer dot-product stage: a sequential MAC turns stretched inputs and weights into a
// squash-table address, then one-weight-per-cycle training from the coded bit.
module mixer_dot #(
    parameter int NI = 4,
    parameter int SW = 12,
    parameter int WW = 24,
    parameter int LR = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NI*SW-1:0]  st,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       aw,
    input  logic [15:0]       p_in,
    input  logic              y_valid,
    input  logic              y
);

    localparam int IW   = $clog2(NI + 1);
    localparam int PW   = SW + WW;
    localparam int ACCW = PW + 4;
    localparam int EW   = 20;
    localparam int TW   = SW + EW;
    localparam int SUMW = ((TW > WW) ? TW : WW) + 1;
    localparam logic signed [WW-1:0]   W_INIT = WW'(65536 / NI);
    localparam logic signed [SUMW-1:0] W_MAX  = {{(SUMW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [SUMW-1:0] W_MIN  = -W_MAX;

    typedef enum logic [2:0] {IDLE, MAC, OUT, WAIT_Y, TRAIN} state_t;

    state_t                  state_q, state_d;
    logic signed [SW-1:0]    st_q [NI];
    logic signed [SW-1:0]    st_d [NI];
    logic signed [WW-1:0]    w_q  [NI];
    logic signed [WW-1:0]    w_d  [NI];
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [11:0]             aw_q, aw_d;
    logic [15:0]             p_q, p_d;
    logic signed [EW-1:0]    err_q, err_d;
    logic                    in_ready_q, out_valid_q;

    logic [IW-1:0]           sel_s;
    logic signed [SW-1:0]    sel_st_s;
    logic signed [WW-1:0]    sel_w_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [ACCW-1:0]  dot_s;
    logic signed [11:0]      dclamp_s;
    logic [15:0]             p_sh_s;
    logic signed [EW-1:0]    diff_s;
    logic signed [TW-1:0]    tprod_s;
    logic signed [TW-1:0]    delta_s;
    logic signed [SUMW-1:0]  sum_s;
    logic signed [WW-1:0]    wsat_s;

    // Datapath: operand select, MAC product, address clamp, error and saturated weight update.
    always_comb begin
        sel_s    = (idx_q < IW'(NI)) ? idx_q : '0;
        sel_st_s = st_q[sel_s];
        sel_w_s  = w_q[sel_s];
        prod_s   = sel_st_s * sel_w_s;
        dot_s    = acc_q >>> 16;
        if (dot_s > ACCW'(2047)) begin
            dclamp_s = 12'sd2047;
        end else if (dot_s < -ACCW'(2047)) begin
            dclamp_s = -12'sd2047;
        end else begin
            dclamp_s = dot_s[11:0];
        end
        p_sh_s  = p_q >> 3;
        diff_s  = $signed({7'b0, y, 12'b0}) - $signed({4'b0, p_sh_s});
        tprod_s = sel_st_s * err_q;
        delta_s = tprod_s >>> 10;
        sum_s   = SUMW'(sel_w_s) + SUMW'(delta_s);
        if (sum_s > W_MAX) begin
            wsat_s = W_MAX[WW-1:0];
        end else if (sum_s < W_MIN) begin
            wsat_s = W_MIN[WW-1:0];
        end else begin
            wsat_s = sum_s[WW-1:0];
        end
    end

    // Next-state logic of the bundle sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        aw_d    = aw_q;
        p_d     = p_q;
        err_d   = err_q;
        st_d    = st_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < NI; i++) begin
                        st_d[i] = st[i*SW +: SW];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                // One extra cycle after the last product registers the clamped address.
                if (idx_q == IW'(NI)) begin
                    aw_d    = dclamp_s + 12'd2048;
                    state_d = OUT;
                end else begin
                    acc_d = acc_q + ACCW'(prod_s);
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    p_d     = p_in;
                    state_d = WAIT_Y;
                end else begin
                    state_d = OUT;
                end
            end
            WAIT_Y: begin
                if (y_valid) begin
                    err_d   = diff_s * $signed(EW'(LR));
                    idx_d   = '0;
                    state_d = TRAIN;
                end else begin
                    state_d = WAIT_Y;
                end
            end
            TRAIN: begin
                w_d[sel_s] = wsat_s;
                idx_d      = idx_q + 1'b1;
                if (idx_q == IW'(NI - 1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = TRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; reset restores the initial weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            aw_q        <= 12'd2048;
            p_q         <= 16'd0;
            err_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NI; i++) begin
                st_q[i] <= '0;
                w_q[i]  <= W_INIT;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            aw_q        <= aw_d;
            p_q         <= p_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == OUT);
            for (int i = 0; i < NI; i++) begin
                st_q[i] <= st_d[i];
                w_q[i]  <= w_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign aw        = aw_q;

endmodule
